// File: rtl/alu_seq.sv
// alu_seq: multi-cycle integer ALU with RV32M-style multiply/divide.
//
// Operand bundles enter through an in_valid/in_ready handshake, and results
// leave through an out_valid/out_ready handshake. ADD, SUB, AND, OR, XOR,
// illegal ops and the divide fast paths finish in one cycle. MUL/MULHU use
// an iterative unsigned shift-add engine. DIV/DIVU/REM/REMU use a restoring
// divider on magnitudes, with a sign fixup when the engine finishes.
//
// Build option: define ALU_SEQ_MULDIV_EN to compile in the MUL/DIV engines.
// When it is not defined, ops 5..10 are reported as illegal.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand bundle valid
//   in_ready   block is idle and can accept a bundle
//   op         operation select (0 ADD .. 10 REMU, 11..15 illegal)
//   a, b       operands
//   out_valid  result valid
//   out_ready  consumer accepts the result
//   result     registered result
//   zero       result == 0
//   err        illegal or compiled-out op, qualified by out_valid
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             err
);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;

`ifdef ALU_SEQ_MULDIV_EN
    localparam logic [3:0] OP_MUL  = 4'd5;
    localparam logic [3:0] OP_MULHU = 4'd6;
    localparam logic [3:0] OP_DIV  = 4'd7;
    localparam logic [3:0] OP_DIVU = 4'd8;
    localparam logic [3:0] OP_REM  = 4'd9;
    localparam logic [3:0] OP_REMU = 4'd10;

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;
`else
    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_DONE = 1'b1
    } state_t;
`endif

    function automatic logic [WIDTH-1:0] simple_op(input logic [3:0] f,
                                                   input logic [WIDTH-1:0] x,
                                                   input logic [WIDTH-1:0] y);
        case (f)
            OP_ADD:  return x + y;
            OP_SUB:  return x - y;
            OP_AND:  return x & y;
            OP_OR:   return x | y;
            default: return x ^ y;
        endcase
    endfunction

    state_t           state;
    state_t           state_next;
    logic             accept;
    logic             is_simple;
    logic             load;
    logic [WIDTH-1:0] res_next;
    logic             err_next;

    assign accept    = in_valid && (state == S_IDLE);
    assign is_simple = (op <= OP_XOR);

`ifdef ALU_SEQ_MULDIV_EN
    logic                    is_mul;
    logic                    is_div;
    logic                    is_rem;
    logic                    div_sgn;
    logic                    div_fast;
    logic [WIDTH-1:0]        fast_res;
    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    logic [WIDTH-1:0]        a_mag;
    logic [WIDTH-1:0]        b_mag;

    logic [2*WIDTH-1:0]      acc;
    logic [WIDTH-1:0]        opa_q;
    logic [WIDTH-1:0]        opb_q;
    logic [CNT_W-1:0]        cnt;
    logic [3:0]              op_q;
    logic                    neg_q;
    logic                    neg_r;
    logic                    last;

    logic [WIDTH:0]          mul_hi;
    logic [2*WIDTH-1:0]      mul_acc_next;
    logic [WIDTH:0]          div_trial;
    logic [2*WIDTH-1:0]      div_acc_next;
    logic [WIDTH-1:0]        quot;
    logic [WIDTH-1:0]        remd;
    logic [WIDTH-1:0]        mul_res;
    logic [WIDTH-1:0]        div_res;

    assign a_s      = a;
    assign b_s      = b;
    assign is_mul   = (op == OP_MUL) || (op == OP_MULHU);
    assign is_div   = (op >= OP_DIV) && (op <= OP_REMU);
    assign is_rem   = (op == OP_REM) || (op == OP_REMU);
    assign div_sgn  = (op == OP_DIV) || (op == OP_REM);
    // Divide by zero, or the one signed quotient that does not fit.
    assign div_fast = (b == '0) || (div_sgn && (a == MOST_NEG) && (&b));
    assign fast_res = (b == '0) ? (is_rem ? a : {WIDTH{1'b1}})
                                : (is_rem ? '0 : MOST_NEG);
    // Negating MOST_NEG yields MOST_NEG, which is the correct magnitude
    // when read as unsigned.
    assign a_mag    = (div_sgn && a[WIDTH-1]) ? WIDTH'(-a_s) : a;
    assign b_mag    = (div_sgn && b[WIDTH-1]) ? WIDTH'(-b_s) : b;

    assign last = (cnt == CNT_W'(1));

    // Shift-add: add the multiplicand into the upper half when the current
    // multiplier bit is set, then shift the whole accumulator right.
    assign mul_hi       = {1'b0, acc[2*WIDTH-1:WIDTH]}
                        + {1'b0, opa_q & {WIDTH{opb_q[0]}}};
    assign mul_acc_next = {mul_hi, acc[WIDTH-1:1]};
    assign mul_res      = (op_q == OP_MUL) ? mul_acc_next[WIDTH-1:0]
                                           : mul_acc_next[2*WIDTH-1:WIDTH];

    // Restoring divide: acc = {partial remainder, dividend/quotient}.
    assign div_trial    = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opb_q};
    assign div_acc_next = div_trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                        : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    assign quot         = div_acc_next[WIDTH-1:0];
    assign remd         = div_acc_next[2*WIDTH-1:WIDTH];
    assign div_res      = ((op_q == OP_REM) || (op_q == OP_REMU))
                        ? (neg_r ? -remd : remd)
                        : (neg_q ? -quot : quot);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            opa_q <= '0;
            opb_q <= '0;
            cnt   <= '0;
            op_q  <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q  <= op;
                        cnt   <= CNT_W'(WIDTH);
                        opa_q <= a;
                        opb_q <= b_mag;
                        acc   <= is_mul ? '0 : {{WIDTH{1'b0}}, a_mag};
                        neg_q <= div_sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_r <= div_sgn && a[WIDTH-1];
                    end
                end
                S_MUL: begin
                    acc   <= mul_acc_next;
                    opb_q <= opb_q >> 1;
                    cnt   <= cnt - CNT_W'(1);
                end
                S_DIV: begin
                    acc <= div_acc_next;
                    cnt <= cnt - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
`ifdef ALU_SEQ_MULDIV_EN
                    if (is_mul)                  state_next = S_MUL;
                    else if (is_div && !div_fast) state_next = S_DIV;
                    else                         state_next = S_DONE;
`else
                    state_next = S_DONE;
`endif
                end
            end
`ifdef ALU_SEQ_MULDIV_EN
            S_MUL, S_DIV: begin
                if (last) state_next = S_DONE;
            end
`endif
            S_DONE: begin
                if (out_ready) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == S_IDLE);
        out_valid = (state == S_DONE);
    end

    // Decide when the output registers load and with what.
    always_comb begin
        load     = 1'b0;
        res_next = '0;
        err_next = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    load = 1'b1;
                    if (is_simple) begin
                        res_next = simple_op(op, a, b);
`ifdef ALU_SEQ_MULDIV_EN
                    end else if (is_div && div_fast) begin
                        res_next = fast_res;
                    end else if (is_mul || is_div) begin
                        load = 1'b0;
`endif
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
`ifdef ALU_SEQ_MULDIV_EN
            S_MUL: begin
                if (last) begin
                    load     = 1'b1;
                    res_next = mul_res;
                end
            end
            S_DIV: begin
                if (last) begin
                    load     = 1'b1;
                    res_next = div_res;
                end
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result <= '0;
            zero   <= 1'b1;
            err    <= 1'b0;
        end else if (load) begin
            result <= res_next;
            zero   <= (res_next == '0);
            err    <= err_next;
        end
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, multi-cycle successor to the single-cycle integer ALU. It adds RV32M-style multiply, divide and remainder, implemented as iterative shift-add and restoring-divide engines. Operands enter through a valid/ready handshake and results leave through a second valid/ready handshake. It sits in the execute stage beside the combinational ALU, and the pipeline stalls on `in_ready`/`out_valid`.

## Interface
Parameters:
- `WIDTH`, default 32: operand and result width; must be ≥ 4 and even.
- `CNT_W`, default `$clog2(WIDTH)+1`: iteration counter width. Derived; do not override.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand bundle valid.
- `in_ready`  out  1  block can accept a bundle.
- `op`  in  4  operation select: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 MUL (low half), 6 MULHU (high half, unsigned), 7 DIV, 8 DIVU, 9 REM, 10 REMU. Codes 11–15 are illegal.
- `a`  in  WIDTH  operand A.
- `b`  in  WIDTH  operand B.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `result`  out  WIDTH  result.
- `zero`  out  1  `result == 0`.
- `err`  out  1  illegal or compiled-out op; qualified by `out_valid`.

## Operation
- States: IDLE, MUL, DIV, DONE.
- `in_ready` = (state == IDLE). A bundle is accepted when `in_valid && in_ready`. Accepting latches `op`, `a` and `b`.
- IDLE transitions on accept:
  - ADD/SUB/AND/OR/XOR: compute and register the result, then go to DONE.
  - MUL/MULHU: clear the 2·WIDTH accumulator, load the counter with WIDTH, go to MUL.
  - DIV/DIVU/REM/REMU with the fast-path condition: go straight to DONE. The fast-path conditions are below.
  - All other DIV/DIVU/REM/REMU: go to DIV.
  - Illegal op: `result` = 0, `err` = 1, go to DONE.
- MUL: one multiplier bit per cycle, LSB first, unsigned shift-add. After WIDTH iterations go to DONE. MUL returns the low WIDTH bits; MULHU returns the high WIDTH bits.
- DIV:
  - Signed ops first take magnitudes of both operands.
  - Restoring division, one quotient bit per cycle, WIDTH iterations, then go to DONE.
  - Sign fixup is applied on exit: the quotient is negated when the operand signs differ; the remainder takes the sign of the dividend.
- Fast paths (1-cycle, no iteration):
  - Divide by zero: quotient = all ones; remainder = `a`. Applies to both signed and unsigned.
  - Signed overflow (`a` = most-negative, `b` = −1): quotient = most-negative; remainder = 0.
- DONE: `out_valid` = 1. `result`, `zero` and `err` are held stable until `out_valid && out_ready`, then the block returns to IDLE.
- Arithmetic wraps modulo 2^WIDTH. No overflow flag exists.

## Timing
- Reset values: state IDLE, `in_ready` = 1, `out_valid` = 0, `result` = 0, `zero` = 1, `err` = 0. Counter and accumulators are 0.
- Latency is measured from the accept edge to the first cycle `out_valid` is high:
  - Logic ops, ADD, SUB, illegal ops, div fast paths: 1 cycle.
  - MUL/MULHU: WIDTH+1 cycles.
  - Non-fast-path DIV/DIVU/REM/REMU: WIDTH+1 cycles.
- `in_ready` is low from the cycle after accept until the cycle after the output handshake. Peak throughput is one simple op per 2 cycles.
- `out_ready` may be held high in advance. The result then lasts exactly one cycle.
- Outputs are registered; there is no combinational path from `a`/`b`/`op` to any output.
- `in_valid` while busy is ignored. The held `a`, `b` and `op` are unaffected by input changes after accept.
- Reset asserted mid-operation: the block returns to the reset values immediately (asynchronously) and discards the partial result.

## Configuration
- `ALU_SEQ_MULDIV_EN` defined: MUL, DIV and their states, counter and datapath are compiled in; all behaviour is as above.
- Not defined: the MUL/DIV states and datapath are removed. Ops 5–10 are treated as illegal: 1-cycle latency, `result` = 0, `err` = 1. ADD/SUB/AND/OR/XOR are unchanged.

## Test plan
- Reset, then ADD with `a` = 5, `b` = 7, `out_ready` = 1 → `out_valid` high 1 cycle after accept, `result` = 12, `zero` = 0, `in_ready` high again the next cycle.
- SUB with `a` = `b` = 0x1234 → `result` = 0, `zero` = 1. XOR with 0xFFFF0000 ^ 0x0F0F0F0F → 0xF0F00F0F.
- MUL 0xFFFFFFFF × 2 at WIDTH = 32 → `result` = 0xFFFFFFFE after 33 cycles. MULHU of the same operands → 0x00000001.
- DIV −7 / 2 → −3. REM −7 / 2 → −1. DIVU 7 / 0 → 0xFFFFFFFF in 1 cycle. REM 0x80000000 / −1 → 0 in 1 cycle.
- Backpressure: `out_ready` held low 10 cycles after a DIVU 100 / 9 → `result` = 11 stays stable, `in_ready` stays low, and a new `in_valid` is ignored.
- `rst_n` pulsed low mid-MUL (cycle 10) → `out_valid` = 0 and `in_ready` = 1 immediately. The next ADD 1 + 1 returns 2.
- Op 13 (illegal; also any of ops 5–10 with the macro undefined) → `err` = 1, `result` = 0, `zero` = 1.
